// File: rtl/ram_acc_ctrl_64x23.sv
// Read-modify-write controller for a 64x23 single-port RAM with 1-cycle read latency.
// Saturating accumulate / query commands, full-RAM clear after reset or on request.
module ram_acc_ctrl_64x23 #(
  parameter int ADR_WD = 6,
  parameter int DAT_WD = 23,
  parameter int DLT_WD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              cmd_val_i,
  input  logic              cmd_op_i,
  input  logic [ADR_WD-1:0] cmd_adr_i,
  input  logic [DLT_WD-1:0] cmd_dlt_i,
  output logic              cmd_rdy_o,
  output logic              qry_val_o,
  output logic [DAT_WD-1:0] qry_dat_o,
  output logic              busy_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  localparam int SUM_WD = DAT_WD + 2;

  typedef enum logic [2:0] {S_BOOT, S_INIT, S_IDLE, S_RD, S_WB} state_t;

  state_t              state_q, state_d;
  logic [ADR_WD-1:0]   clr_cnt_q, clr_cnt_d;
  logic                op_q, op_d;
  logic [ADR_WD-1:0]   adr_q, adr_d;
  logic [DLT_WD-1:0]   dlt_q, dlt_d;
  logic                qry_val_q, qry_val_d;
  logic [DAT_WD-1:0]   qry_dat_q, qry_dat_d;

  logic [SUM_WD-1:0]   sum;
  logic [DAT_WD-1:0]   sat_dat;

  // Two guard bits: top bit flags a negative result, the next one an overflow.
  always_comb begin
    sum = {2'b00, ram_rd_dat_i} + {{(SUM_WD-DLT_WD){dlt_q[DLT_WD-1]}}, dlt_q};
    if (sum[SUM_WD-1])
      sat_dat = '0;
    else if (sum[SUM_WD-2])
      sat_dat = '1;
    else
      sat_dat = sum[DAT_WD-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      clr_cnt_q <= '0;
      op_q      <= 1'b0;
      adr_q     <= '0;
      dlt_q     <= '0;
      qry_val_q <= 1'b0;
      qry_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      op_q      <= op_d;
      adr_q     <= adr_d;
      dlt_q     <= dlt_d;
      qry_val_q <= qry_val_d;
      qry_dat_q <= qry_dat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    op_d      = op_q;
    adr_d     = adr_q;
    dlt_d     = dlt_q;
    qry_val_d = 1'b0;
    qry_dat_d = qry_dat_q;
    case (state_q)
      S_BOOT: begin
        state_d   = S_INIT;
        clr_cnt_d = '0;
      end
      S_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1)
          state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clr_i) begin
          state_d   = S_INIT;
          clr_cnt_d = '0;
        end else if (cmd_val_i) begin
          op_d    = cmd_op_i;
          adr_d   = cmd_adr_i;
          dlt_d   = cmd_dlt_i;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_WB;
      S_WB: begin
        if (op_q) begin
          qry_val_d = 1'b1;
          qry_dat_d = ram_rd_dat_i;
        end
        if (cmd_val_i) begin
          op_d    = cmd_op_i;
          adr_d   = cmd_adr_i;
          dlt_d   = cmd_dlt_i;
          state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    cmd_rdy_o    = 1'b0;
    busy_o       = 1'b0;
    ram_adr_o    = '0;
    ram_wr_ena_o = 1'b0;
    ram_wr_dat_o = '0;
    ram_rd_ena_o = 1'b0;
    case (state_q)
      S_BOOT: busy_o = 1'b1;
      S_INIT: begin
        busy_o       = 1'b1;
        ram_wr_ena_o = 1'b1;
        ram_adr_o    = clr_cnt_q;
      end
      S_IDLE: cmd_rdy_o = ~clr_i;
      S_RD: begin
        ram_rd_ena_o = 1'b1;
        ram_adr_o    = adr_q;
      end
      S_WB: begin
        cmd_rdy_o = 1'b1;
        if (!op_q) begin
          ram_wr_ena_o = 1'b1;
          ram_adr_o    = adr_q;
          ram_wr_dat_o = sat_dat;
        end
      end
      default: ;
    endcase
  end

  assign qry_val_o = qry_val_q;
  assign qry_dat_o = qry_dat_q;

endmodule

// File: tb/tb_ram_acc_ctrl_64x23.sv
// Directed bench for ram_acc_ctrl_64x23 with a behavioural 64x23 RAM and a query scoreboard.
module tb_ram_acc_ctrl_64x23;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_i = 1'b0;
  logic        cmd_val_i = 1'b0;
  logic        cmd_op_i = 1'b0;
  logic [5:0]  cmd_adr_i = '0;
  logic [7:0]  cmd_dlt_i = '0;
  logic        cmd_rdy_o;
  logic        qry_val_o;
  logic [22:0] qry_dat_o;
  logic        busy_o;
  logic [5:0]  ram_adr_o;
  logic        ram_wr_ena_o;
  logic [22:0] ram_wr_dat_o;
  logic        ram_rd_ena_o;
  logic [22:0] ram_rd_dat;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int both_cnt = 0;

  typedef struct {
    logic [22:0] dat;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  int   model [64];

  logic [22:0] mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_adr = '0;
  logic [22:0] poke_dat = '0;

  ram_acc_ctrl_64x23 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr_i),
    .cmd_val_i    (cmd_val_i),
    .cmd_op_i     (cmd_op_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_dlt_i    (cmd_dlt_i),
    .cmd_rdy_o    (cmd_rdy_o),
    .qry_val_o    (qry_val_o),
    .qry_dat_o    (qry_dat_o),
    .busy_o       (busy_o),
    .ram_adr_o    (ram_adr_o),
    .ram_wr_ena_o (ram_wr_ena_o),
    .ram_wr_dat_o (ram_wr_dat_o),
    .ram_rd_ena_o (ram_rd_ena_o),
    .ram_rd_dat_i (ram_rd_dat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM with 1-cycle read latency; the poke port preloads words while the DUT is idle.
  always @(posedge clk) begin
    if (poke_en)
      mem[poke_adr] <= poke_dat;
    else if (ram_wr_ena_o)
      mem[ram_adr_o] <= ram_wr_dat_o;
    if (ram_rd_ena_o)
      ram_rd_dat <= mem[ram_adr_o];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Query scoreboard: every output pulse must match the oldest outstanding query.
  always @(negedge clk) begin
    if (ram_rd_ena_o === 1'b1 && ram_wr_ena_o === 1'b1)
      both_cnt++;
    if (rst_n && qry_val_o === 1'b1) begin
      n_chk++;
      assert (exp_q.size() != 0)
      else begin
        n_fail++;
        $error("FAIL qry_unexpected: observed pulse with data %0h expected no pulse", qry_dat_o);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("qry_dat", qry_dat_o, e.dat);
        chk("qry_latency", cyc - e.cyc, 3);
        $display("query result data=%06h latency=%0d", qry_dat_o, cyc - e.cyc);
      end
    end
  end

  // Entered on a negedge where busy_o is high; that cycle counts toward the busy total.
  task automatic run_sweep(input int exp_busy);
    int nb = 0;
    int nw = 0;
    int bad = 0;
    int g = 0;
    while (busy_o === 1'b1 && g < 200) begin
      nb++;
      if (ram_wr_ena_o === 1'b1) begin
        if (ram_adr_o !== nw[5:0] || ram_wr_dat_o !== 23'd0) bad++;
        nw++;
      end
      @(negedge clk);
      g++;
    end
    chk("sweep_busy_cycles", nb, exp_busy);
    chk("sweep_writes", nw, 64);
    chk("sweep_seq_bad", bad, 0);
    chk("sweep_rdy_after", cmd_rdy_o, 1);
    for (int i = 0; i < 64; i++) model[i] = 0;
    $display("sweep busy=%0d writes=%0d bad=%0d", nb, nw, bad);
  endtask

  task automatic poke(input logic [5:0] adr, input logic [22:0] dat);
    poke_en = 1'b1;
    poke_adr = adr;
    poke_dat = dat;
    @(negedge clk);
    poke_en = 1'b0;
    model[adr] = dat;
    $display("preload adr=%0d data=%06h", adr, dat);
  endtask

  task automatic issue(input logic op, input logic [5:0] adr, input logic [7:0] dlt,
                       output int acc_cyc);
    int g = 0;
    int s;
    cmd_val_i = 1'b1;
    cmd_op_i = op;
    cmd_adr_i = adr;
    cmd_dlt_i = dlt;
    #1;
    while (cmd_rdy_o !== 1'b1 && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("accept_timeout", cmd_rdy_o, 1);
    acc_cyc = cyc;
    if (op) begin
      exp_q.push_back('{dat: model[adr][22:0], cyc: cyc});
    end else begin
      s = model[adr] + int'($signed(dlt));
      if (s < 0) s = 0;
      if (s > 23'h7FFFFF) s = 23'h7FFFFF;
      model[adr] = s;
    end
    $display("cmd op=%0d adr=%0d dlt=%0d cyc=%0d", op, adr, $signed(dlt), acc_cyc);
    @(negedge clk);
    cmd_val_i = 1'b0;
  endtask

  initial begin
    int a0, a1, a9;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 1);
    chk("rst_rdy", cmd_rdy_o, 0);
    chk("rst_wr_ena", ram_wr_ena_o, 0);
    chk("rst_rd_ena", ram_rd_ena_o, 0);
    chk("rst_qry_val", qry_val_o, 0);
    chk("rst_qry_dat", qry_dat_o, 0);
    rst_n = 1'b1;
    run_sweep(65);

    issue(1'b0, 6'd5, 8'd3, a0);
    issue(1'b1, 6'd5, 8'd0, a1);
    chk("b2b_gap", a1 - a0, 2);

    poke(6'd9, 23'h7FFFFE);
    issue(1'b0, 6'd9, 8'd5, a0);
    issue(1'b1, 6'd9, 8'd0, a0);
    poke(6'd10, 23'd2);
    issue(1'b0, 6'd10, 8'hF9, a0);
    issue(1'b1, 6'd10, 8'd0, a0);
    poke(6'd20, 23'd1000);
    issue(1'b0, 6'd20, 8'h80, a0);
    issue(1'b0, 6'd20, 8'd127, a0);
    issue(1'b1, 6'd20, 8'd0, a0);

    issue(1'b0, 6'd12, 8'd1, a0);
    for (int i = 1; i < 10; i++) issue(1'b0, 6'd12, 8'd1, a9);
    chk("burst_gap", a9 - a0, 18);
    issue(1'b1, 6'd12, 8'd0, a0);
    repeat (4) @(negedge clk);

    clr_i = 1'b1;
    cmd_val_i = 1'b1;
    cmd_op_i = 1'b1;
    cmd_adr_i = 6'd12;
    #1;
    chk("clr_rdy_low", cmd_rdy_o, 0);
    @(negedge clk);
    clr_i = 1'b0;
    cmd_val_i = 1'b0;
    chk("clr_busy", busy_o, 1);
    run_sweep(64);
    issue(1'b1, 6'd12, 8'd0, a0);
    issue(1'b1, 6'd5, 8'd0, a0);
    repeat (4) @(negedge clk);

    poke(6'd3, 23'd100);
    cmd_val_i = 1'b1;
    cmd_op_i = 1'b0;
    cmd_adr_i = 6'd3;
    cmd_dlt_i = 8'd9;
    #1;
    chk("rmw_rst_accept", cmd_rdy_o, 1);
    @(negedge clk);
    cmd_val_i = 1'b0;
    chk("rmw_rst_rd_ena", ram_rd_ena_o, 1);
    chk("rmw_rst_rd_adr", ram_adr_o, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmw_rst_no_wr", ram_wr_ena_o, 0);
    chk("rmw_rst_busy", busy_o, 1);
    rst_n = 1'b1;
    run_sweep(65);
    issue(1'b1, 6'd3, 8'd0, a0);

    for (int g = 0; g < 10 && exp_q.size() != 0; g++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("rd_wr_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
